// File: rtl/jtag_mem_bridge.sv
// Single-chain JTAG-to-memory bridge: one user DR carries {op, payload}.
// Define JTAG_MEM_AUTOINC_EN to post-increment ADDR after each WRITE/READ.
module jtag_mem_bridge #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 32,
  parameter int RD_LAT   = 2,
  parameter int ADDR_INC = 8
) (
  input  logic              TCK,
  input  logic              RESET,
  input  logic              SEL,
  input  logic              CAPTURE,
  input  logic              SHIFT,
  input  logic              UPDATE,
  input  logic              TDI,
  output logic              TDO,
  output logic              WREN,
  output logic              RDEN,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] TO_MEM,
  input  logic [DATA_W-1:0] FROM_MEM,
  output logic              BUSY,
  output logic [5:0]        DBG
);

  localparam int SR_W = DATA_W + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WSTB  = 2'd1,
    RWAIT = 2'd2
  } state_t;

  state_t            state;
  logic [SR_W-1:0]   sr;
  logic [DATA_W-1:0] rdbuf;
  logic              vld;
  logic              ovr;
  logic [1:0]        op;
  logic [3:0]        cnt;
  logic [1:0]        cmd;
  logic [ADDR_W-1:0] addr_next;

  if (ADDR_W > DATA_W) begin : g_bad_aw
    $error("ADDR_W must not exceed DATA_W");
  end
  if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_lat
    $error("RD_LAT must be in 1..15");
  end
  if (ADDR_INC < 0) begin : g_bad_inc
    $error("ADDR_INC must be non-negative");
  end

  assign cmd = sr[SR_W-1:DATA_W];

`ifdef JTAG_MEM_AUTOINC_EN
  assign addr_next = ADDR + ADDR_W'(ADDR_INC);
`else
  assign addr_next = ADDR;
`endif

  assign DBG = {2'(state), ovr, vld, op};

  always_ff @(posedge TCK) begin
    if (RESET) begin
      sr     <= '0;
      ADDR   <= '0;
      TO_MEM <= '0;
      WREN   <= 1'b0;
      RDEN   <= 1'b0;
      BUSY   <= 1'b0;
      rdbuf  <= '0;
      vld    <= 1'b0;
      ovr    <= 1'b0;
      op     <= 2'b00;
      cnt    <= 4'd0;
      TDO    <= 1'b0;
      state  <= IDLE;
    end else begin
      WREN <= 1'b0;
      RDEN <= 1'b0;
      if (SEL && UPDATE) begin
        op <= cmd;
        if (cmd != 2'b00) begin
          if (BUSY) begin
            ovr <= 1'b1;
          end else if (state == IDLE) begin
            unique case (cmd)
              2'b01: ADDR <= sr[ADDR_W-1:0];
              2'b10: begin
                TO_MEM <= sr[DATA_W-1:0];
                WREN   <= 1'b1;
                state  <= WSTB;
              end
              2'b11: begin
                RDEN  <= 1'b1;
                BUSY  <= 1'b1;
                cnt   <= 4'(RD_LAT);
                state <= RWAIT;
              end
              default: ;
            endcase
          end
        end
      end else if (SEL && CAPTURE) begin
        sr  <= {ovr, vld, rdbuf};
        ovr <= 1'b0;
        vld <= 1'b0;
      end else if (SEL && SHIFT) begin
        sr  <= {TDI, sr[SR_W-1:1]};
        TDO <= sr[0];
      end

      // A completing read sets vld after any same-cycle capture clear.
      unique case (state)
        WSTB: begin
          ADDR  <= addr_next;
          state <= IDLE;
        end
        RWAIT: begin
          if (cnt == 4'd0) begin
            rdbuf <= FROM_MEM;
            vld   <= 1'b1;
            ADDR  <= addr_next;
            BUSY  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
